// File: rtl/frame_pkg.sv
// Shared definitions for the frame packer that feeds the 16-input X/O/none
// classifier: FSM state encoding, verdict codes and default frame geometry.
package frame_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        WAIT    = 2'd1,
        RESULT  = 2'd2
    } state_t;

    localparam logic [1:0] RES_O       = 2'b00;
    localparam logic [1:0] RES_X       = 2'b01;
    localparam logic [1:0] RES_NONE    = 2'b10;
    localparam logic [1:0] RES_TIMEOUT = 2'b11;

    localparam int DEF_N     = 16;
    localparam int DEF_PIX_W = 8;

endpackage

// File: rtl/frame_shift.sv
// Pixel thresholding, MSB-first staging shift register and beat counter.
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   beat        : a pixel beat is accepted this edge (already qualified by ena)
//   pix_data    : pixel sample
//   pix_last    : beat carries the frame's last-pixel marker
//   frame_done  : accepted beat completes a well-formed N-pixel frame
//   frame_err   : accepted beat ends a short frame or overruns N pixels
//   frame_vec   : completed vector (valid when frame_done); pixel 0 in MSB
module frame_shift
    import frame_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int PIX_W  = DEF_PIX_W,
    parameter int THRESH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             beat,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             pix_last,
    output logic             frame_done,
    output logic             frame_err,
    output logic [N-1:0]     frame_vec
);

    localparam int               CNT_W    = $clog2(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [PIX_W-1:0] THRESH_V = PIX_W'(THRESH);

    // Only N-1 bits need storing: the N-th bit comes straight from the
    // incoming beat when the frame completes.
    logic [N-2:0]     stage;
    logic [CNT_W-1:0] cnt;
    logic             pix_bit;
    logic             at_last;

    function automatic logic threshold(input logic [PIX_W-1:0] p);
        return (p >= THRESH_V);
    endfunction

    always_comb begin
        pix_bit    = threshold(pix_data);
        at_last    = (cnt == CNT_LAST);
        frame_done = beat & pix_last & at_last;
        // Marker and count disagree: either too few pixels before the marker
        // or the N-th pixel arrived without one.
        frame_err  = beat & (pix_last ^ at_last);
        frame_vec  = {stage, pix_bit};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage <= '0;
            cnt   <= '0;
        end else if (beat) begin
            if (pix_last | at_last) begin
                stage <= '0;
                cnt   <= '0;
            end else begin
                stage <= frame_vec[N-2:0];
                cnt   <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_packer.sv
// Frame packer: collects N thresholded pixels over valid/ready, launches the
// classifier with a one-cycle start, holds data stable while it runs, then
// offers the 2-bit verdict downstream over valid/ack with a timeout guard.
// Ports:
//   clk, rst, ena        : clock, synchronous active-high reset, clock enable
//   pix_valid/data/last  : pixel stream in; pix_ready is the accept qualifier
//   data, start          : packed frame and launch pulse to the classifier
//   rdy, res             : classifier done pulse and verdict
//   cls_valid, cls_res   : verdict offered downstream; cls_ack consumes it
//   err                  : one-ena-cycle pulse on framing error or timeout
module frame_packer
    import frame_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int PIX_W   = DEF_PIX_W,
    parameter int THRESH  = 128,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             pix_last,
    output logic             pix_ready,
    output logic [N-1:0]     data,
    output logic             start,
    input  logic             rdy,
    input  logic [1:0]       res,
    output logic             cls_valid,
    output logic [1:0]       cls_res,
    input  logic             cls_ack,
    output logic             err
);

    localparam int                TCNT_W    = $clog2(TIMEOUT + 1);
    // The counter is cleared on the launch edge and increments on each later
    // ena edge, so the TIMEOUT-th edge after start sees TIMEOUT-1.
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    state_t            state, state_n;
    logic [TCNT_W-1:0] tcnt, tcnt_n;
    logic [N-1:0]      data_n;
    logic              start_n;
    logic              cls_valid_n;
    logic [1:0]        cls_res_n;
    logic              err_n;

    logic              beat;
    logic              frame_done;
    logic              frame_err;
    logic [N-1:0]      frame_vec;

    assign pix_ready = ena & (state == COLLECT) & ~rst;
    assign beat      = pix_valid & pix_ready;

    frame_shift #(
        .N      (N),
        .PIX_W  (PIX_W),
        .THRESH (THRESH)
    ) u_shift (
        .clk        (clk),
        .rst        (rst),
        .beat       (beat),
        .pix_data   (pix_data),
        .pix_last   (pix_last),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .frame_vec  (frame_vec)
    );

    always_comb begin
        state_n     = state;
        tcnt_n      = tcnt;
        data_n      = data;
        start_n     = 1'b0;
        cls_valid_n = cls_valid;
        cls_res_n   = cls_res;
        err_n       = 1'b0;
        case (state)
            COLLECT: begin
                if (frame_done) begin
                    data_n  = frame_vec;
                    start_n = 1'b1;
                    tcnt_n  = '0;
                    state_n = WAIT;
                end
                if (frame_err) begin
                    err_n = 1'b1;
                end
            end
            WAIT: begin
                tcnt_n = tcnt + 1'b1;
                // rdy takes priority over a timeout on the same edge.
                if (rdy) begin
                    cls_res_n   = res;
                    cls_valid_n = 1'b1;
                    state_n     = RESULT;
                end else if (tcnt == TCNT_LAST) begin
                    cls_res_n   = RES_TIMEOUT;
                    cls_valid_n = 1'b1;
                    err_n       = 1'b1;
                    state_n     = RESULT;
                end
            end
            RESULT: begin
                if (cls_ack) begin
                    cls_valid_n = 1'b0;
                    state_n     = COLLECT;
                end
            end
            default: begin
                state_n = COLLECT;
            end
        endcase
    end

    // Register stage: everything, including start and err, holds while ena is
    // low so pulses last exactly one ena cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            tcnt      <= '0;
            data      <= '0;
            start     <= 1'b0;
            cls_valid <= 1'b0;
            cls_res   <= RES_O;
            err       <= 1'b0;
        end else if (ena) begin
            state     <= state_n;
            tcnt      <= tcnt_n;
            data      <= data_n;
            start     <= start_n;
            cls_valid <= cls_valid_n;
            cls_res   <= cls_res_n;
            err       <= err_n;
        end
    end

endmodule

// File: tb/tb_frame_packer.sv
// Self-checking bench for frame_packer: randomized pixel frames, ena gaps and
// classifier latencies, checked against a transaction-level reference model.
module tb_frame_packer;
    import frame_pkg::*;

    localparam int N       = 16;
    localparam int PIX_W   = 8;
    localparam int THRESH  = 128;
    localparam int TIMEOUT = 255;

    logic             clk = 1'b0;
    logic             rst;
    logic             ena;
    logic             pix_valid;
    logic [PIX_W-1:0] pix_data;
    logic             pix_last;
    logic             pix_ready;
    logic [N-1:0]     data;
    logic             start;
    logic             rdy;
    logic [1:0]       res;
    logic             cls_valid;
    logic [1:0]       cls_res;
    logic             cls_ack;
    logic             err;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit           mbits[$];
    logic [N-1:0] exp_data;
    logic         m_err;
    logic [1:0]   m_res;
    logic         m_tmo;
    logic [7:0]   fr[0:31];

    always #5 clk = ~clk;

    frame_packer #(
        .N       (N),
        .PIX_W   (PIX_W),
        .THRESH  (THRESH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_last  (pix_last),
        .pix_ready (pix_ready),
        .data      (data),
        .start     (start),
        .rdy       (rdy),
        .res       (res),
        .cls_valid (cls_valid),
        .cls_res   (cls_res),
        .cls_ack   (cls_ack),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] pack_bits();
        logic [N-1:0] v = '0;
        for (int i = 0; i < N; i++) v[N-1-i] = mbits[i];
        return v;
    endfunction

    task automatic fill_alt(input logic [7:0] a, input logic [7:0] b);
        for (int i = 0; i < 32; i++) fr[i] = (i % 2 == 0) ? a : b;
    endtask

    task automatic fill_const(input logic [7:0] v);
        for (int i = 0; i < 32; i++) fr[i] = v;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 32; i++) fr[i] = 8'($urandom);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        ena       = 1'b1;
        pix_valid = 1'b1;
        pix_data  = 8'($urandom);
        pix_last  = 1'b0;
        rdy       = 1'b0;
        cls_ack   = 1'b0;
        #1;
        chk("rst_pix_ready", pix_ready, 0);
        tick();
        chk("rst_data", data, 0);
        chk("rst_start", start, 0);
        chk("rst_cls_valid", cls_valid, 0);
        chk("rst_cls_res", cls_res, 0);
        chk("rst_err", err, 0);
        rst       = 1'b0;
        pix_valid = 1'b0;
        mbits.delete();
        exp_data  = '0;
        m_err     = 1'b0;
    endtask

    // Offer one pixel until accepted; model checks follow each edge.
    task automatic send_beat(input logic [7:0] px, input logic last, input bit gaps);
        bit acc   = 1'b0;
        int guard = 0;
        bit done, e;
        while (!acc && guard < 100) begin
            guard++;
            ena       = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            pix_valid = 1'b1;
            pix_data  = px;
            pix_last  = last;
            rdy       = 1'($urandom);
            res       = 2'($urandom);
            #1;
            acc = pix_ready;
            chk("collect_pix_ready", pix_ready, ena);
            tick();
            if (acc) begin
                mbits.push_back(px >= THRESH);
                done = last && (mbits.size() == N);
                e    = (last && mbits.size() < N) || (!last && mbits.size() == N);
                if (done) exp_data = pack_bits();
                if (done || e) mbits.delete();
                m_err = e;
                chk("beat_start", start, done);
                chk("beat_err", err, e);
            end else begin
                if (ena) m_err = 1'b0;
                chk("hold_start", start, 0);
                chk("hold_err", err, m_err);
            end
            chk("collect_data", data, exp_data);
            chk("collect_cls_valid", cls_valid, 0);
        end
        if (!acc) chk("beat_accept", acc, 1);
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    task automatic send_frame(input int len, input bit last_on_end, input bit gaps);
        for (int i = 0; i < len; i++) send_beat(fr[i], last_on_end && (i == len - 1), gaps);
    endtask

    // lat = ena-edge count after start at which rdy is given; 0 = never.
    task automatic wait_result(input int lat, input logic [1:0] r, input bit gap3);
        int j     = 0;
        int it    = 0;
        bit got   = 1'b0;
        m_tmo     = 1'b0;
        pix_valid = 1'($urandom);
        while (!got && it < 2000) begin
            ena = (gap3 && it < 3) ? 1'b0 : ($urandom_range(0, 4) != 0);
            it++;
            rdy = ena ? 1'b0 : 1'($urandom);
            res = 2'($urandom);
            if (ena && (j + 1 == lat)) begin
                rdy = 1'b1;
                res = r;
            end
            #1;
            chk("wait_pix_ready", pix_ready, 0);
            tick();
            if (ena) begin
                j++;
                if (lat != 0 && j == lat) begin
                    got   = 1'b1;
                    m_res = r;
                end else if (j == TIMEOUT) begin
                    got   = 1'b1;
                    m_tmo = 1'b1;
                    m_res = RES_TIMEOUT;
                end
            end
            if (!got) begin
                chk("wait_cls_valid", cls_valid, 0);
                chk("wait_start", start, (j == 0));
                chk("wait_err", err, 0);
            end
            chk("wait_data", data, exp_data);
        end
        if (!got) chk("wait_bound", got, 1);
        rdy = 1'b0;
        chk("res_cls_valid", cls_valid, 1);
        chk("res_cls_res", cls_res, m_res);
        chk("res_err", err, m_tmo);
    endtask

    task automatic take_result(input int hold);
        logic e_exp = m_tmo;
        pix_valid = 1'b0;
        for (int h = 0; h < hold; h++) begin
            ena     = ($urandom_range(0, 3) != 0);
            cls_ack = ena ? 1'b0 : 1'($urandom);
            rdy     = 1'($urandom);
            #1;
            chk("hold_pix_ready", pix_ready, 0);
            tick();
            if (ena) e_exp = 1'b0;
            chk("hold_cls_valid", cls_valid, 1);
            chk("hold_cls_res", cls_res, m_res);
            chk("hold_res_err", err, e_exp);
            chk("hold_res_data", data, exp_data);
        end
        ena     = 1'b1;
        cls_ack = 1'b1;
        rdy     = 1'b0;
        #1;
        tick();
        cls_ack = 1'b0;
        chk("ack_cls_valid", cls_valid, 0);
        chk("ack_err", err, 0);
        chk("ack_pix_ready", pix_ready, 1);
        m_err = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; pix_valid = 1'b0; pix_data = '0; pix_last = 1'b0;
        rdy = 1'b0; res = '0; cls_ack = 1'b0;
        exp_data = '0; m_err = 1'b0; m_res = '0; m_tmo = 1'b0;
        do_reset();
        do_reset();

        fill_alt(8'd200, 8'd10);
        send_frame(16, 1, 0);
        chk("alt_data", data, 16'hAAAA);
        wait_result(3, RES_X, 0);
        take_result(2);

        fill_alt(8'd127, 8'd128);
        send_frame(16, 1, 1);
        chk("thresh_data", data, 16'h5555);
        wait_result(5, RES_O, 1);
        take_result(1);

        fill_const(8'd128);
        send_frame(16, 1, 0);
        chk("all128_data", data, 16'hFFFF);
        wait_result(2, RES_NONE, 0);
        take_result(0);

        fill_rand();
        send_frame(5, 1, 0);
        fill_const(8'd0);
        send_frame(16, 1, 0);
        chk("zero_data", data, 16'h0000);
        wait_result(4, RES_X, 0);
        take_result(1);

        fill_rand();
        send_frame(16, 0, 1);
        fill_rand();
        send_frame(16, 1, 1);
        wait_result(1, 2'($urandom), 0);
        take_result(3);

        fill_rand();
        send_frame(16, 1, 0);
        wait_result(0, RES_O, 1);
        take_result(20);

        fill_rand();
        send_frame(16, 1, 0);
        wait_result(TIMEOUT, RES_NONE, 0);
        take_result(1);

        fill_rand();
        send_frame(8, 0, 0);
        do_reset();
        fill_rand();
        send_frame(16, 1, 0);
        wait_result(6, RES_X, 0);
        take_result(2);

        fill_rand();
        send_frame(16, 1, 0);
        for (int i = 0; i < 5; i++) begin
            ena = 1'b1;
            rdy = 1'b0;
            tick();
        end
        do_reset();
        fill_rand();
        send_frame(16, 1, 1);
        wait_result(7, RES_O, 0);
        take_result(2);

        for (int k = 0; k < 6; k++) begin
            fill_rand();
            send_frame(16, 1, 1);
            wait_result($urandom_range(1, 40), 2'($urandom), 1'($urandom));
            take_result($urandom_range(0, 5));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
